// File: rtl/top_level.sv
// top_level: fixed-function compute engine with a 256x8 data memory and a
// 16x8 scratch register file. Each launch runs the next task in the rotation
// P1 (16-bit negate) -> P2 (3-byte sort) -> P3 (16-bit popcount).
// Optional feature macro: TOPLEVEL_CYCLE_COUNT_EN. When it is defined, the
// busy-cycle count of each completed task is written to core[255].

// Data memory: combinational read, synchronous write, one access per cycle.
module data_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] core [0:DEPTH-1];

  assign o_rdata = core[i_addr];

  // Synchronous write port.
  // NOTE: storage arrays get no reset: contents must survive rst_n, and a
  // reset would turn the array into flops instead of RAM. Sequential state
  // always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) core[i_addr] <= i_wdata;
  end
endmodule

// Scratch register file: two combinational read ports, two write ports.
// The compare-swap and negate steps need to update two registers at once.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic [RW-1:0]     i_ra0,
  input  logic [RW-1:0]     i_ra1,
  output logic [DATA_W-1:0] o_rd0,
  output logic [DATA_W-1:0] o_rd1,
  input  logic              i_we0,
  input  logic [RW-1:0]     i_wa0,
  input  logic [DATA_W-1:0] i_wd0,
  input  logic              i_we1,
  input  logic [RW-1:0]     i_wa1,
  input  logic [DATA_W-1:0] i_wd1
);
  logic [DATA_W-1:0] registers [0:NREGS-1];

  assign o_rd0 = registers[i_ra0];
  assign o_rd1 = registers[i_ra1];

  // Two write ports; the engine never targets the same register on both.
  always_ff @(posedge clk) begin
    if (i_we0) registers[i_wa0] <= i_wd0;
    if (i_we1) registers[i_wa1] <= i_wd1;
  end
endmodule

module top_level #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int NREGS     = 16
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic start,
  output logic halt
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_STORE, S_DONE} state_t;
  typedef enum logic [1:0] {T_NEG, T_SORT, T_POP} task_t;

  state_t r_state, w_next_state;
  task_t  r_task, w_task_nxt;
  logic [4:0] r_step;
  logic       r_halt;

  logic [4:0]        w_load_len, w_exec_len, w_store_len, w_phase_len;
  logic [AW-1:0]     w_load_base, w_store_base;
  logic [RW-1:0]     w_store_src;
  logic              w_last, w_run, w_busy, w_task_done;

  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata, w_mem_rdata;

  logic [RW-1:0]     w_ra0, w_ra1, w_wa0, w_wa1;
  logic [DATA_W-1:0] w_rd0, w_rd1, w_wd0, w_wd1;
  logic              w_we0, w_we1;
  logic [2*DATA_W-1:0] w_neg;
  logic              w_bit;

  logic              w_cnt_wr;
  logic [DATA_W-1:0] w_cnt_val;

  data_mem #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) data_mem1 (
    .clk(CLK), .i_we(w_mem_we), .i_addr(w_mem_addr),
    .i_wdata(w_mem_wdata), .o_rdata(w_mem_rdata)
  );

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) reg_file1 (
    .clk(CLK),
    .i_ra0(w_ra0), .i_ra1(w_ra1), .o_rd0(w_rd0), .o_rd1(w_rd1),
    .i_we0(w_we0), .i_wa0(w_wa0), .i_wd0(w_wd0),
    .i_we1(w_we1), .i_wa1(w_wa1), .i_wd1(w_wd1)
  );

  // start high means "stay idle / abort"; all work is gated on it being low.
  assign w_run       = ~start;
  assign w_busy      = (r_state == S_LOAD) || (r_state == S_EXEC) || (r_state == S_STORE);
  assign w_last      = (r_step == w_phase_len - 5'd1);
  assign w_task_done = (r_state == S_STORE) && (w_next_state == S_DONE);
  assign halt        = r_halt;

  // Per-task phase lengths, operand/result addresses and rotation successor.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_load_len   = 5'd2;
    w_exec_len   = 5'd1;
    w_store_len  = 5'd2;
    w_load_base  = AW'(8);
    w_store_base = AW'(10);
    w_store_src  = RW'(2);
    w_task_nxt   = T_SORT;
    case (r_task)
      T_NEG: ;
      T_SORT: begin
        w_load_len   = 5'd3;
        w_exec_len   = 5'd3;
        w_store_len  = 5'd3;
        w_load_base  = AW'(0);
        w_store_base = AW'(4);
        w_store_src  = RW'(0);
        w_task_nxt   = T_POP;
      end
      default: begin
        w_load_len   = 5'd2;
        w_exec_len   = 5'd16;
        w_store_len  = 5'd1;
        w_load_base  = AW'(12);
        w_store_base = AW'(14);
        w_store_src  = RW'(2);
        w_task_nxt   = T_NEG;
      end
    endcase
  end

  // Next-state logic: phases advance on their last step, start aborts to IDLE.
  always_comb begin
    w_next_state = r_state;
    w_phase_len  = 5'd1;
    case (r_state)
      S_IDLE:  if (w_run) w_next_state = S_LOAD;
      S_LOAD: begin
        w_phase_len = w_load_len;
        if (start)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_phase_len = w_exec_len;
        if (start)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_STORE;
      end
      S_STORE: begin
        w_phase_len = w_store_len;
        if (start)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE:  if (start) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: memory and register-file port steering for each phase/task.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_ra0       = '0;
    w_ra1       = '0;
    w_we0       = 1'b0;
    w_wa0       = '0;
    w_wd0       = '0;
    w_we1       = 1'b0;
    w_wa1       = '0;
    w_wd1       = '0;
    w_neg       = '0;
    w_bit       = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_mem_addr = w_load_base + AW'(r_step);
        w_we0      = w_run;
        w_wa0      = RW'(r_step);
        w_wd0      = w_mem_rdata;
      end
      S_EXEC: begin
        case (r_task)
          T_NEG: begin
            // registers[0] holds the MSB; result lands in registers[2..3].
            w_ra0 = RW'(0);
            w_ra1 = RW'(1);
            w_neg = ~{w_rd0, w_rd1} + (2*DATA_W)'(1);
            w_we0 = w_run;
            w_wa0 = RW'(2);
            w_wd0 = w_neg[2*DATA_W-1:DATA_W];
            w_we1 = w_run;
            w_wa1 = RW'(3);
            w_wd1 = w_neg[DATA_W-1:0];
          end
          T_SORT: begin
            // Compare-swap pairs (0,1), (1,2), (0,1); swap only on strictly
            // greater so equal values keep their order.
            w_ra0 = (r_step == 5'd1) ? RW'(1) : RW'(0);
            w_ra1 = w_ra0 + RW'(1);
            if (w_rd0 > w_rd1) begin
              w_we0 = w_run;
              w_wa0 = w_ra0;
              w_wd0 = w_rd1;
              w_we1 = w_run;
              w_wa1 = w_ra1;
              w_wd1 = w_rd0;
            end
          end
          default: begin
            // Steps 0-7 walk the low byte (registers[1]), 8-15 the high byte;
            // the running count lives in registers[2], restarted at step 0.
            w_ra0 = r_step[3] ? RW'(0) : RW'(1);
            w_ra1 = RW'(2);
            w_bit = w_rd0[r_step[2:0]];
            w_we0 = w_run;
            w_wa0 = RW'(2);
            w_wd0 = ((r_step == 5'd0) ? '0 : w_rd1) + DATA_W'(w_bit);
          end
        endcase
      end
      S_STORE: begin
        w_ra0       = w_store_src + RW'(r_step);
        w_mem_addr  = w_store_base + AW'(r_step);
        w_mem_we    = w_run;
        w_mem_wdata = w_rd0;
      end
      S_DONE: begin
        w_mem_addr  = '1;
        w_mem_we    = w_cnt_wr;
        w_mem_wdata = w_cnt_val;
      end
      default: ;
    endcase
  end

  // State register, step counter, registered halt and task rotation.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_task  <= T_NEG;
      r_step  <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_halt  <= (w_next_state == S_DONE);
      if (w_next_state != r_state) r_step <= '0;
      else if (w_busy)             r_step <= r_step + 5'd1;
      if (w_task_done) r_task <= w_task_nxt;
    end
  end

`ifdef TOPLEVEL_CYCLE_COUNT_EN
  logic [7:0] r_cyc_cnt;
  logic       r_cnt_pending;

  // Busy-cycle counter: restarts on LOAD entry, saturates, and flags one
  // write to core[255] in the first DONE cycle (the entry edge belongs to
  // the last result store).
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt     <= '0;
      r_cnt_pending <= 1'b0;
    end else begin
      r_cnt_pending <= w_task_done;
      if (r_state == S_IDLE && w_next_state == S_LOAD) r_cyc_cnt <= '0;
      else if (w_busy && r_cyc_cnt != 8'hFF)          r_cyc_cnt <= r_cyc_cnt + 8'd1;
    end
  end

  assign w_cnt_wr  = r_cnt_pending;
  assign w_cnt_val = DATA_W'(r_cyc_cnt);
`else
  assign w_cnt_wr  = 1'b0;
  assign w_cnt_val = '0;
`endif

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: randomized and directed task launches
// checked against a behavioural memory model, plus abort and reset cases.
`timescale 1ns/1ps
module tb_top_level;
  logic CLK = 1'b0;
  logic rst_n;
  logic start;
  logic halt;

  int n_checks = 0;
  int n_errors = 0;
  int next_task = 0;

  logic [7:0]  model [0:255];
  logic [15:0] p1_dir [0:2] = '{16'h0000, 16'h0001, 16'h8000};
  logic [23:0] p2_dir [0:2] = '{24'h000407, 24'h070004, 24'h050501};
  logic [15:0] p3_dir [0:2] = '{16'hFFFF, 16'h0000, 16'h8001};

  top_level dut (.CLK(CLK), .rst_n(rst_n), .start(start), .halt(halt));

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_byte(input int addr, input logic [7:0] val);
    dut.data_mem1.core[addr] = val;
    model[addr] = val;
  endtask

  // Apply the task's architectural effect to the model memory.
  task automatic apply_model(input int t);
    int x, y, a, b, c, lo, hi, cnt;
    case (t)
      0: begin
        x = {16'h0, model[8], model[9]};
        y = (65536 - x) % 65536;
        model[10] = 8'(y / 256);
        model[11] = 8'(y % 256);
      end
      1: begin
        a = int'(model[0]); b = int'(model[1]); c = int'(model[2]);
        lo = (a < b) ? a : b; lo = (lo < c) ? lo : c;
        hi = (a > b) ? a : b; hi = (hi > c) ? hi : c;
        model[4] = 8'(lo);
        model[5] = 8'(a + b + c - lo - hi);
        model[6] = 8'(hi);
      end
      default: begin
        x = {16'h0, model[12], model[13]};
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += (x >> i) & 1;
        model[14] = 8'(cnt);
      end
    endcase
`ifdef TOPLEVEL_CYCLE_COUNT_EN
    model[255] = (t == 0) ? 8'd5 : (t == 1) ? 8'd9 : 8'd19;
`endif
  endtask

  task automatic set_inputs(input int t, input bit directed, input int idx);
    logic [23:0] v;
    case (t)
      0: begin
        v = directed ? {8'h0, p1_dir[idx]} : 24'($urandom);
        set_byte(8, v[15:8]); set_byte(9, v[7:0]);
      end
      1: begin
        v = directed ? p2_dir[idx] : 24'($urandom);
        set_byte(0, v[23:16]); set_byte(1, v[15:8]); set_byte(2, v[7:0]);
      end
      default: begin
        v = directed ? {8'h0, p3_dir[idx]} : 24'($urandom);
        set_byte(12, v[15:8]); set_byte(13, v[7:0]);
      end
    endcase
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.data_mem1.core[i] !== model[i]) bad++;
    check({tag, "_mem_bytes_wrong"}, bad, 0);
  endtask

  // Drop start, wait (bounded) for halt, check latency and the results.
  task automatic launch_wait(input string tag);
    int cyc, t, exp_lat;
    t = next_task;
    exp_lat = (t == 0) ? 6 : (t == 1) ? 10 : 20;
    @(negedge CLK);
    start = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (halt === 1'b1) break;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    apply_model(t);
    next_task = (t + 1) % 3;
    case (t)
      0: begin
        check({tag, "_p1_hi"}, dut.data_mem1.core[10], model[10]);
        check({tag, "_p1_lo"}, dut.data_mem1.core[11], model[11]);
        check({tag, "_reg0"}, dut.reg_file1.registers[0], model[8]);
        check({tag, "_reg1"}, dut.reg_file1.registers[1], model[9]);
      end
      1: begin
        check({tag, "_p2_0"}, dut.data_mem1.core[4], model[4]);
        check({tag, "_p2_1"}, dut.data_mem1.core[5], model[5]);
        check({tag, "_p2_2"}, dut.data_mem1.core[6], model[6]);
      end
      default: check({tag, "_p3"}, dut.data_mem1.core[14], model[14]);
    endcase
  endtask

  task automatic release_start(input string tag);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); #1;
    check({tag, "_halt_drop"}, halt, 1'b0);
    compare_mem(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 256; i++) set_byte(i, 8'h00);
    for (int i = 0; i < 16; i++) dut.reg_file1.registers[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1 check("reset_halt", halt, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Directed rounds: each task three times in rotation.
    for (int k = 0; k < 9; k++) begin
      set_inputs(next_task, 1'b1, k / 3);
      launch_wait($sformatf("dir%0d", k));
      release_start($sformatf("dir%0d", k));
      if (k == 0) begin
        check("first_p1_in_hi", dut.data_mem1.core[8], 8'h00);
        for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom_range(0, 255)));
      end
    end

    // Abort mid-P3, then rerun it.
    for (int k = 0; k < 2; k++) begin
      set_inputs(next_task, 1'b0, 0);
      launch_wait($sformatf("pre_abort%0d", k));
      release_start($sformatf("pre_abort%0d", k));
    end
    set_inputs(next_task, 1'b0, 0);
    set_byte(14, 8'hA5);
    @(negedge CLK);
    start = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      check("abort_busy_halt", halt, 1'b0);
    end
    @(negedge CLK);
    start = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("abort_idle_halt", halt, 1'b0);
    end
    check("abort_p3_untouched", dut.data_mem1.core[14], 8'hA5);
    compare_mem("abort");
    launch_wait("rerun_p3");
    release_start("rerun_p3");

    // Randomized launches.
    for (int k = 0; k < 9; k++) begin
      set_inputs(next_task, 1'b0, 0);
      launch_wait($sformatf("rnd%0d", k));
      release_start($sformatf("rnd%0d", k));
    end

    // Hold start low after DONE: halt stays, no relaunch.
    set_inputs(next_task, 1'b0, 0);
    launch_wait("hold");
    repeat (4) @(posedge CLK);
    #1 check("hold_halt", halt, 1'b1);
    compare_mem("hold");
    release_start("hold");

    // Reset while halted (after P2): halt drops at once, index back to P1.
    set_inputs(next_task, 1'b0, 0);
    launch_wait("rst_done");
    @(posedge CLK);
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1 check("rst_done_halt", halt, 1'b0);
    start = 1'b1;
    next_task = 0;
    @(negedge CLK);
    rst_n = 1'b1;
    compare_mem("rst_done");

    // Reset mid-P1 load, then P1 reruns from the start of the rotation.
    set_inputs(next_task, 1'b0, 0);
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b0;
    #1 check("rst_mid_halt", halt, 1'b0);
    start = 1'b1;
    @(negedge CLK);
    rst_n = 1'b1;
    compare_mem("rst_mid");
    set_inputs(next_task, 1'b1, 2);
    launch_wait("after_rst_p1");
    release_start("after_rst_p1");
`ifdef TOPLEVEL_CYCLE_COUNT_EN
    check("cycle_count_p1", dut.data_mem1.core[255], 8'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Self-contained fixed-function compute engine with an internal 256x8 data memory and a 16x8 scratch register file.
- Each launch runs the next of three built-in tasks (P1, P2, P3) in fixed rotation. Each task reads operands from fixed memory addresses and writes results back to memory, then raises halt.
- The bench preloads memory and registers hierarchically and reads results back the same way.

Parameters:
DATA_W, 8, byte width of memory and registers
MEM_DEPTH, 256, data memory entries (8-bit address)
NREGS, 16, scratch register count

Ports:
CLK  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level; high = hold engine idle, falling to low launches the current task
halt  output  1  high when the current task has completed; held until start goes high

Behaviour:
- Hierarchy (required, bench accesses these directly):
  - Data memory instance data_mem1 with array core[0:255] of 8 bits.
  - Register file instance reg_file1 with array registers[0:15] of 8 bits.
  - Neither is cleared by rst_n; contents persist across tasks.
- Memory model: combinational read, synchronous write on CLK rising edge, one access per cycle.
- Reset (rst_n low, async): FSM=IDLE, task index=0, halt=0.
- FSM states: IDLE -> LOAD -> EXEC -> STORE -> DONE.
  - IDLE: entered while start=1. On the first rising edge with start=0, go to LOAD.
  - LOAD: one operand byte per cycle, memory into registers[0..].
  - EXEC: compute in registers.
  - STORE: one result byte per cycle into memory.
  - DONE: halt=1 (registered, asserts on the edge after the last store). Task index advances 0->1->2->0.
- Task P1 (index 0): 16-bit two's-complement negate.
  - Input {core[8],core[9]}, core[8] = MSB.
  - Output {core[10],core[11]} = (~x+1) mod 2^16.
  - Latency: 2 load + 1 exec + 2 store.
- Task P2 (index 1): unsigned ascending sort of core[0],core[1],core[2] into core[4],core[5],core[6].
  - Sorting network of 3 compare-swap cycles.
  - Equal values keep their relative order.
  - Latency: 3 load + 3 exec + 3 store.
- Task P3 (index 2): population count of {core[12],core[13]} into core[14] (0..16).
  - 1 bit examined per cycle.
  - Latency: 2 load + 16 exec + 1 store.
- Input addresses are never written by any task.
- start=1 in any non-IDLE state: abort immediately (next edge) to IDLE, halt=0.
  - Task index does not advance on abort; the same task reruns on the next launch.
  - Stores already committed before the abort remain in memory.
- start=1 while in DONE: halt drops next edge, FSM goes to IDLE, index already advanced.
- start held low after DONE: stay in DONE, halt stays 1, no relaunch.
- Addresses outside those listed are untouched, except core[255] under the optional feature.

Optional Feature:
- Macro TOPLEVEL_CYCLE_COUNT_EN.
- Defined:
  - An 8-bit saturating counter clears on entry to LOAD and increments each cycle until DONE.
  - On entry to DONE, its value is written to core[255].
  - Expected values: P1=5, P2=9, P3=19.
- Undefined: no counter; core[255] is never written.

Test Plan:
- Reset, clear memory and registers, core[8..9]=00 00, release start -> halt within 6 cycles; core[10..11]=00 00; core[8..9] unchanged.
- Pulse start, core[0..2]=00 04 07 -> halt; core[4..6]=00 04 07. Repeat P2 with inputs 07 00 04 -> 00 04 07; with 05 05 01 -> 01 05 05.
- Pulse start, {core[12],core[13]}=65535 -> halt; core[14]=16 (0x10). Inputs 0x0000 -> 0; 0x8001 -> 2.
- P1 with 0x0001 -> FF FF; with 0x8000 -> 80 00; fourth launch wraps to P1 (index 0).
- Raise start mid-P3 (cycle 8) -> halt stays 0, core[14] unchanged. Relaunch -> P3 reruns and completes correctly.
- Assert rst_n low mid-task -> halt=0 immediately; next launch runs P1. With TOPLEVEL_CYCLE_COUNT_EN: core[255]=5 after P1.
